// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage between instruction memory and the core's decode stage. Owns the
//   fetch PC, issues word reads over a level req/ack interface and presents each
//   fetched word with its PC to the core over a valid/ready handshake. Redirects
//   from downstream replace the fetch PC; a read already in flight when a redirect
//   arrives is allowed to finish and its data is dropped.
//
//   Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count and
//   stall_count performance counter outputs.
//
// Ports
//   clk          in   system clock, rising edge
//   start_up     in   synchronous active-high reset
//   imem_req     out  read request, held until imem_ack
//   imem_addr    out  read address, stable while imem_req is high
//   imem_ack     in   read data valid this cycle
//   imem_rdata   in   instruction word from memory
//   instr_valid  out  instruction/pc_out valid to the core
//   instr_ready  in   core accepts the instruction this cycle
//   instruction  out  fetched instruction word
//   pc_out       out  address of the presented instruction
//   redirect     in   fetch from redirect_pc
//   redirect_pc  in   new fetch address, bits [1:0] ignored
//   fetch_count  out  accepted handshakes, saturating (FETCH_PERF_CNT_EN only)
//   stall_count  out  cycles waiting on imem_ack, saturating (FETCH_PERF_CNT_EN only)
//
// state | meaning
// START | one idle cycle after reset, no request
// FETCH | request at pc, waiting for ack
// HOLD  | instruction presented, waiting for the core to take it
// DROP  | pre-redirect read still in flight; its data is thrown away
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0020
) (
   input  logic              clk,
   input  logic              start_up,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instruction,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              redirect,
`ifdef FETCH_PERF_CNT_EN
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
`else
   input  logic [ADDR_W-1:0] redirect_pc
`endif
);

   typedef enum logic [1:0] {START, FETCH, HOLD, DROP} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] drop_addr;
   logic [ADDR_W-1:0] redir_aligned;
   logic              unused_redir_lsb;

   assign redir_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redir_lsb = &{1'b0, redirect_pc[1:0]};

   assign imem_req  = (state == FETCH) || (state == DROP);
   // in DROP the bus must keep showing the address of the abandoned read
   assign imem_addr = (state == DROP) ? drop_addr : pc;

   always_ff @(posedge clk) begin
      if (start_up) begin
         state       <= START;
         pc          <= RESET_PC;
         drop_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instruction <= 32'h0;
         pc_out      <= RESET_PC;
      end else begin
         case (state)
            START: state <= FETCH;
            FETCH: begin
               if (redirect) begin
                  pc <= redir_aligned;
                  if (!imem_ack) begin
                     drop_addr <= pc;
                     state     <= DROP;
                  end
               end else if (imem_ack) begin
                  instruction <= imem_rdata;
                  pc_out      <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc + ADDR_W'(4);
                  state       <= HOLD;
               end
            end
            DROP: begin
               if (redirect) pc <= redir_aligned;
               // the ack closes the old read even if another redirect lands now
               if (imem_ack) state <= FETCH;
            end
            HOLD: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  pc          <= redir_aligned;
                  state       <= FETCH;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: state <= START;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (start_up) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if ((state == HOLD) && instr_ready && !redirect && (fetch_count != 32'hFFFF_FFFF))
            fetch_count <= fetch_count + 32'd1;
         if (imem_req && !imem_ack && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        start_up;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk         (clk),
      .start_up    (start_up),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .pc_out      (pc_out),
      .redirect    (redirect),
`ifdef FETCH_PERF_CNT_EN
      .redirect_pc (redirect_pc),
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`else
      .redirect_pc (redirect_pc)
`endif
   );

   typedef struct {
      logic        su;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic su, logic ack, logic [31:0] rdata, logic rdy,
                               logic e_req, logic [31:0] e_addr, logic e_valid,
                               logic [31:0] e_instr, logic [31:0] e_pc);
      vec_t v;
      v.su = su; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start_up = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; imem_rdata = 32'h0;
      step();
      start_up = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      //             su ack rdata         rdy req addr          val instr         pc_out
      vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0040_0020);
      vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0040_0020);
      vecs[2]  = mk(0, 1, 32'hFFBF_FFDF, 1, 1, 32'h0040_0020, 0, 32'h0,         32'h0040_0020);
      vecs[3]  = mk(0, 1, 32'h0,         1, 0, 32'h0,         1, 32'hFFBF_FFDF, 32'h0040_0020);
      vecs[4]  = mk(0, 1, 32'hFFBF_FFDB, 1, 1, 32'h0040_0024, 0, 32'hFFBF_FFDF, 32'h0040_0020);
      vecs[5]  = mk(0, 1, 32'h0,         1, 0, 32'h0,         1, 32'hFFBF_FFDB, 32'h0040_0024);
      vecs[6]  = mk(0, 1, 32'hFFBF_FFD7, 1, 1, 32'h0040_0028, 0, 32'hFFBF_FFDB, 32'h0040_0024);
      for (int i = 7; i < 12; i++)
         vecs[i] = mk(0, 1, 32'h0,       0, 0, 32'h0,         1, 32'hFFBF_FFD7, 32'h0040_0028);
      vecs[12] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFBF_FFD7, 32'h0040_0028);
      vecs[13] = mk(0, 0, 32'h0,         0, 1, 32'h0040_002C, 0, 32'hFFBF_FFD7, 32'h0040_0028);

      start_up = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      step();

      // reset, streaming with ack tied high, and a held instruction
      for (int i = 0; i < 14; i++) begin
         start_up = vecs[i].su; imem_ack = vecs[i].ack;
         imem_rdata = vecs[i].rdata; instr_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
         if (vecs[i].e_req) chk($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
         chk($sformatf("v%0d instr", i), instruction, vecs[i].e_instr);
         chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
         step();
      end

      // ack delayed three cycles: address held for four request cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wait%0d req", i), {31'h0, imem_req}, 32'h1);
         chk($sformatf("wait%0d addr", i), imem_addr, 32'h0040_0020);
         step();
      end
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
      chk("wait3 addr", imem_addr, 32'h0040_0020);
      step();
      imem_ack = 1'b0;
      chk("wait valid", {31'h0, instr_valid}, 32'h1);
      chk("wait instr", instruction, 32'hAAAA_5555);
      chk("wait pc_out", pc_out, 32'h0040_0020);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_count", stall_count, 32'd3);
      chk("fetch_count0", fetch_count, 32'd0);
`endif
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("wait next addr", imem_addr, 32'h0040_0024);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count1", fetch_count, 32'd1);
`endif

      // redirect while ack pending: late ack is discarded
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h0040_0100;
      step();
      redirect = 1'b0;
      chk("drop req", {31'h0, imem_req}, 32'h1);
      chk("drop addr", imem_addr, 32'h0040_0020);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("drop valid", {31'h0, instr_valid}, 32'h0);
      chk("drop instr", instruction, 32'h0);
      chk("drop new addr", imem_addr, 32'h0040_0100);
      chk("drop new req", {31'h0, imem_req}, 32'h1);

      // second redirect while in DROP, then squash in HOLD, then ack+redirect
      redirect = 1'b1; redirect_pc = 32'h0040_0140;
      step();
      redirect_pc = 32'h0040_0180;
      chk("drop2 addr", imem_addr, 32'h0040_0100);
      step();
      redirect = 1'b0;
      chk("drop3 addr", imem_addr, 32'h0040_0100);
      chk("drop3 req", {31'h0, imem_req}, 32'h1);
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      step();
      chk("drop3 valid", {31'h0, instr_valid}, 32'h0);
      chk("drop3 new addr", imem_addr, 32'h0040_0180);
      imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 1'b0;
      chk("hold pc_out", pc_out, 32'h0040_0180);
      chk("hold instr", instruction, 32'h1234_5678);
      redirect = 1'b1; redirect_pc = 32'h0040_0203; instr_ready = 1'b1;
      step();
      redirect = 1'b0; instr_ready = 1'b0;
      chk("squash valid", {31'h0, instr_valid}, 32'h0);
      chk("squash addr", imem_addr, 32'h0040_0200);
`ifdef FETCH_PERF_CNT_EN
      chk("squash fetch_count", fetch_count, 32'd0);
`endif
      imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0040_0300;
      step();
      imem_ack = 1'b0; redirect = 1'b0;
      chk("ackredir valid", {31'h0, instr_valid}, 32'h0);
      chk("ackredir addr", imem_addr, 32'h0040_0300);

      // PC wrap at the top of the address space
      do_reset();
      imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; instr_ready = 1'b1;
      step();
      redirect = 1'b0; imem_rdata = 32'h0000_0003;
      chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap valid0", {31'h0, instr_valid}, 32'h0);
      step();
      chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
      chk("wrap instr", instruction, 32'h0000_0003);
      step();
      chk("wrap next req", {31'h0, imem_req}, 32'h1);
      chk("wrap next addr", imem_addr, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
